// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: memory address/data, downstream stall/redirect and issue outputs.
// The fetch unit connects through the master modport; the environment uses slave.
interface fetch_unit_if;
    logic [7:0] Read_Address;
    logic [7:0] Instruction;
    logic       Stall;
    logic       Redirect_Valid;
    logic [7:0] Redirect_Addr;
    logic [7:0] Fetched_Instr;
    logic [7:0] Fetched_PC;
    logic       Valid;
    logic       Halted;
    logic [7:0] Fetch_Count;

    modport master (
        output Read_Address, Fetched_Instr, Fetched_PC, Valid, Halted, Fetch_Count,
        input  Instruction, Stall, Redirect_Valid, Redirect_Addr
    );

    modport slave (
        input  Read_Address, Fetched_Instr, Fetched_PC, Valid, Halted, Fetch_Count,
        output Instruction, Stall, Redirect_Valid, Redirect_Addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch unit: PC sequencing with short relative jumps,
// halt on zero-offset jump, downstream stall and execute-stage redirect.
module fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter bit         HALT_DETECT = 1'b1
) (
    input logic          Clk,
    input logic          Reset_N,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {START, RUN, HALT} state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] fpc_q, fpc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       halt_pend_q, halt_pend_d;

    logic       is_jump;
    logic       is_halt;
    logic [7:0] jump_pc;

    always_comb begin
        is_jump = (bus.Instruction[7:6] == 2'b11);
        is_halt = HALT_DETECT && is_jump && (bus.Instruction[1:0] == 2'b00);
        jump_pc = pc_q + {{6{bus.Instruction[1]}}, bus.Instruction[1:0]};

        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        fpc_d       = fpc_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        halt_pend_d = halt_pend_q;

        case (state_q)
            START: state_d = RUN;
            default: begin
                if (bus.Redirect_Valid) begin
                    // Target is fetched on the following edge, giving exactly one bubble.
                    pc_d        = bus.Redirect_Addr;
                    valid_d     = 1'b0;
                    state_d     = RUN;
                    halt_pend_d = 1'b0;
                end else if (state_q == HALT) begin
                    valid_d = 1'b0;
                end else if (bus.Stall) begin
                    state_d = state_q;
                end else if (halt_pend_q) begin
                    // The halting jump was issued last edge; retire it and park.
                    state_d     = HALT;
                    valid_d     = 1'b0;
                    halt_pend_d = 1'b0;
                end else begin
                    ir_d        = bus.Instruction;
                    fpc_d       = pc_q;
                    valid_d     = 1'b1;
                    cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    pc_d        = is_jump ? jump_pc : pc_q + 8'd1;
                    halt_pend_d = is_halt;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= START;
            pc_q        <= RESET_PC;
            ir_q        <= 8'h00;
            fpc_q       <= 8'h00;
            cnt_q       <= 8'h00;
            valid_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            fpc_q       <= fpc_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign bus.Read_Address  = pc_q;
    assign bus.Fetched_Instr = ir_q;
    assign bus.Fetched_PC    = fpc_q;
    assign bus.Valid         = valid_q;
    assign bus.Halted        = (state_q == HALT);
    assign bus.Fetch_Count   = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed program scenarios plus randomized run against a
// behavioural model of the issue stream.
module tb_fetch_unit;
    logic Clk;
    logic Reset_N;
    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(8'h00), .HALT_DETECT(1'b1)) dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    assign bus.Instruction = mem[bus.Read_Address];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {Read_Address, Fetched_Instr, Fetched_PC, Valid, Halted, Fetch_Count}
    wire [33:0] obs = {bus.Read_Address, bus.Fetched_Instr, bus.Fetched_PC,
                       bus.Valid, bus.Halted, bus.Fetch_Count};

    function automatic logic [33:0] pk(input int ra, input int ir, input int fpc,
                                       input int v, input int h, input int cnt);
        return {ra[7:0], ir[7:0], fpc[7:0], v[0], h[0], cnt[7:0]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h44; mem[1] = 8'h49; mem[2] = 8'h18; mem[3] = 8'h89; mem[4] = 8'hC3;
    endtask

    // Reset asserted and released away from the rising edge; START edge follows.
    task automatic apply_reset();
        @(negedge Clk);
        Reset_N = 1'b0;
        bus.Stall = 1'b0;
        bus.Redirect_Valid = 1'b0;
        bus.Redirect_Addr = 8'h00;
        @(negedge Clk);
        Reset_N = 1'b1;
    endtask

    task automatic test_reset();
        load_program();
        @(negedge Clk);
        Reset_N = 1'b0;
        #1;
        n_checks++;
        if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", obs, pk(0, 0, 0, 0, 0, 0));
        end
        @(negedge Clk);
        Reset_N = 1'b1;
    endtask

    task automatic test_sequence();
        logic [33:0] exp_t [8];
        exp_t[0] = pk(0, 8'h00, 0, 0, 0, 0);
        exp_t[1] = pk(1, 8'h44, 0, 1, 0, 1);
        exp_t[2] = pk(2, 8'h49, 1, 1, 0, 2);
        exp_t[3] = pk(3, 8'h18, 2, 1, 0, 3);
        exp_t[4] = pk(4, 8'h89, 3, 1, 0, 4);
        exp_t[5] = pk(3, 8'hC3, 4, 1, 0, 5);
        exp_t[6] = pk(4, 8'h89, 3, 1, 0, 6);
        exp_t[7] = pk(3, 8'hC3, 4, 1, 0, 7);
        load_program();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_t[k]) begin
                n_fail++;
                $display("FAIL sequence edge %0d: got %h want %h", k + 1, obs, exp_t[k]);
            end
        end
    endtask

    task automatic test_stall();
        load_program();
        apply_reset();
        repeat (4) tick();
        bus.Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs !== pk(3, 8'h18, 2, 1, 0, 3)) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got %h want %h", k, obs, pk(3, 8'h18, 2, 1, 0, 3));
            end
        end
        bus.Stall = 1'b0;
        tick();
        n_checks++;
        if (obs !== pk(4, 8'h89, 3, 1, 0, 4)) begin
            n_fail++;
            $display("FAIL stall_resume: got %h want %h", obs, pk(4, 8'h89, 3, 1, 0, 4));
        end
    endtask

    // Continues from test_stall: PC=4, IR=89, count=4.
    task automatic test_redirect_over_stall();
        bus.Stall = 1'b1;
        bus.Redirect_Valid = 1'b1;
        bus.Redirect_Addr = 8'h01;
        tick();
        n_checks++;
        if (obs !== pk(1, 8'h89, 3, 0, 0, 4)) begin
            n_fail++;
            $display("FAIL redirect_bubble: got %h want %h", obs, pk(1, 8'h89, 3, 0, 0, 4));
        end
        bus.Stall = 1'b0;
        bus.Redirect_Valid = 1'b0;
        tick();
        n_checks++;
        if (obs !== pk(2, 8'h49, 1, 1, 0, 5)) begin
            n_fail++;
            $display("FAIL redirect_issue: got %h want %h", obs, pk(2, 8'h49, 1, 1, 0, 5));
        end
    endtask

    task automatic test_halt();
        logic [33:0] exp_t [6];
        logic [1:0]  rv_t  [6];
        exp_t[0] = pk(8'h10, 8'h49, 1, 0, 0, 5);    rv_t[0] = 2'b11;
        exp_t[1] = pk(8'h10, 8'hC0, 8'h10, 1, 0, 6); rv_t[1] = 2'b00;
        exp_t[2] = pk(8'h10, 8'hC0, 8'h10, 0, 1, 6); rv_t[2] = 2'b00;
        exp_t[3] = pk(8'h10, 8'hC0, 8'h10, 0, 1, 6); rv_t[3] = 2'b00;
        exp_t[4] = pk(8'h00, 8'hC0, 8'h10, 0, 0, 6); rv_t[4] = 2'b01;
        exp_t[5] = pk(8'h01, 8'h44, 8'h00, 1, 0, 7); rv_t[5] = 2'b00;
        mem[8'h10] = 8'hC0;
        for (int k = 0; k < 6; k++) begin
            bus.Redirect_Valid = rv_t[k][0];
            bus.Redirect_Addr  = rv_t[k][1] ? 8'h10 : 8'h00;
            tick();
            n_checks++;
            if (obs !== exp_t[k]) begin
                n_fail++;
                $display("FAIL halt step %0d: got %h want %h", k, obs, exp_t[k]);
            end
        end
        bus.Redirect_Valid = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        apply_reset();
        tick();
        for (int k = 2; k <= 301; k++) begin
            tick();
            n_checks++;
            if (obs !== pk((k - 1) % 256, 8'h00, (k - 2) % 256, 1, 0, (k - 1 > 255) ? 255 : k - 1)) begin
                n_fail++;
                $display("FAIL wrap_count edge %0d: got %h want %h", k, obs,
                         pk((k - 1) % 256, 8'h00, (k - 2) % 256, 1, 0, (k - 1 > 255) ? 255 : k - 1));
            end
        end
        n_checks++;
        if (bus.Fetch_Count !== 8'hFF) begin
            n_fail++;
            $display("FAIL count_saturate: got %h want ff", bus.Fetch_Count);
        end
    endtask

    task automatic test_reset_mid_stall();
        load_program();
        apply_reset();
        repeat (4) tick();
        bus.Stall = 1'b1;
        tick();
        #2;
        Reset_N = 1'b0;
        #1;
        n_checks++;
        if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h want %h", obs, pk(0, 0, 0, 0, 0, 0));
        end
        #1;
        bus.Stall = 1'b0;
        Reset_N = 1'b1;
        tick();
        n_checks++;
        if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL restart_start: got %h want %h", obs, pk(0, 0, 0, 0, 0, 0));
        end
        tick();
        n_checks++;
        if (obs !== pk(1, 8'h44, 0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL restart_issue: got %h want %h", obs, pk(1, 8'h44, 0, 1, 0, 1));
        end
    endtask

    // Reference: each productive edge issues mem[pc]; a zero-offset jump is issued,
    // then the next non-stalled edge parks the unit until a redirect.
    task automatic test_random();
        int pc, ir, fpc, v, cnt;
        bit started, halted, halting;
        int off;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        apply_reset();
        pc = 0; ir = 0; fpc = 0; v = 0; cnt = 0;
        started = 0; halted = 0; halting = 0;
        for (int c = 0; c < 600; c++) begin
            bus.Stall          = ($urandom_range(0, 3) == 0);
            bus.Redirect_Valid = ($urandom_range(0, 9) == 0) || (halted && $urandom_range(0, 2) == 0);
            bus.Redirect_Addr  = 8'($urandom);
            b = mem[pc];
            if (!started) begin
                started = 1;
            end else if (bus.Redirect_Valid) begin
                pc = bus.Redirect_Addr; v = 0; halted = 0; halting = 0;
            end else if (halted || bus.Stall) begin
                if (halted) v = 0;
            end else if (halting) begin
                halted = 1; halting = 0; v = 0;
            end else begin
                ir = b; fpc = pc; v = 1;
                cnt = (cnt < 255) ? cnt + 1 : 255;
                if (b[7:6] == 2'b11) begin
                    off = b[1] ? int'(b[1:0]) - 4 : int'(b[1:0]);
                    pc = (pc + off + 256) % 256;
                    halting = (off == 0);
                end else begin
                    pc = (pc + 1) % 256;
                end
            end
            tick();
            n_checks++;
            if (obs !== pk(pc, ir, fpc, v, halted, cnt)) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", c, obs, pk(pc, ir, fpc, v, halted, cnt));
            end
        end
        bus.Stall = 1'b0;
        bus.Redirect_Valid = 1'b0;
    endtask

    initial begin
        Reset_N = 1'b1;
        bus.Stall = 1'b0;
        bus.Redirect_Valid = 1'b0;
        bus.Redirect_Addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_sequence();
        test_stall();
        test_redirect_over_stall();
        test_halt();
        test_wrap_saturate();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
